// File: rtl/mmio_apb_bridge.sv
// mmio_apb_bridge
//   Runs one APB3 read or write per APB-class MMIO command, then returns a
//   5-byte status/read-data response on a byte-wide AXI-S stream.
//   Non-APB commands are ignored and never acked.
// Ports
//   clock, reset         system clock, async active-high reset
//   clr_conf_i           synchronous abort, beats every other event
//   cmd_*                decoded command in; cmd_ack_o one-cycle accept pulse
//   mmio_busy_o          high from accept until the response completes
//   mmio_done_o          one-cycle pulse after the final response byte
//   psel/penable/pwrite/paddr/pwdata, prdata/pready/pslverr   APB3 requester
//   m_tvalid/m_tready/m_tdata/m_tlast                          response stream
module mmio_apb_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr_conf_i,
    input  logic                  cmd_vld_i,
    input  logic                  cmd_dir_i,
    input  logic                  cmd_apb_i,
    output logic                  cmd_ack_o,
    input  logic [3:0]            cmd_tag_i,
    input  logic [15:0]           cmd_len_i,
    input  logic [27:0]           cmd_adr_i,
    output logic                  mmio_busy_o,
    output logic                  mmio_done_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [31:0]           pwdata_o,
    input  logic [31:0]           prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    output logic                  m_tvalid_o,
    output logic                  m_tlast_o,
    input  logic                  m_tready_i,
    output logic [7:0]            m_tdata_o
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  tag_q;
    logic        dir_q;
    logic [31:0] data_q;
    logic        tmo_q, mis_q, err_q;
    logic [15:0] tmo_cnt;
    logic [2:0]  idx;

    logic accept, misaligned, tmo_hit, last_hs;

    always_comb begin
        accept     = (state == IDLE) && cmd_vld_i && cmd_apb_i;
        misaligned = (cmd_adr_i[1:0] != 2'b00);
        // pready on the final allowed cycle still counts as a completion
        tmo_hit    = (state == ACCESS) && !pready_i && (tmo_cnt == TMO_LAST);
        last_hs    = (state == RESP) && m_tready_i && (idx == 3'd4);
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = misaligned ? RESP : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready_i || tmo_hit) state_nxt = RESP;
            RESP:    if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr_conf_i) state_nxt = IDLE;
    end

    // command capture, APB result capture, timeout and byte index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_ack_o   <= 1'b0;
            mmio_busy_o <= 1'b0;
            mmio_done_o <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            tag_q       <= '0;
            dir_q       <= 1'b0;
            data_q      <= '0;
            tmo_q       <= 1'b0;
            mis_q       <= 1'b0;
            err_q       <= 1'b0;
            tmo_cnt     <= '0;
            idx         <= '0;
        end else begin
            cmd_ack_o   <= 1'b0;
            mmio_done_o <= 1'b0;
            if (clr_conf_i) begin
                mmio_busy_o <= 1'b0;
            end else begin
                if (accept) begin
                    cmd_ack_o   <= 1'b1;
                    mmio_busy_o <= 1'b1;
                    tag_q       <= cmd_tag_i;
                    dir_q       <= cmd_dir_i;
                    pwrite_o    <= ~cmd_dir_i;
                    paddr_o     <= cmd_adr_i[ADDR_WIDTH-1:0];
                    pwdata_o    <= {16'h0000, cmd_len_i};
                    data_q      <= '0;
                    tmo_q       <= 1'b0;
                    mis_q       <= misaligned;
                    err_q       <= 1'b0;
                    idx         <= '0;
                end
                if (state == SETUP) tmo_cnt <= '0;
                if (state == ACCESS) begin
                    if (pready_i) begin
                        data_q <= dir_q ? prdata_i : 32'h0;
                        err_q  <= pslverr_i;
                    end else if (tmo_hit) begin
                        tmo_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                if (state == RESP && m_tready_i) begin
                    if (idx == 3'd4) begin
                        idx         <= '0;
                        mmio_done_o <= 1'b1;
                        mmio_busy_o <= 1'b0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
            end
        end
    end

    // outputs decoded from state; response bytes go out little-endian after status
    always_comb begin
        psel_o     = (state == SETUP) || (state == ACCESS);
        penable_o  = (state == ACCESS);
        m_tvalid_o = (state == RESP);
        m_tlast_o  = (state == RESP) && (idx == 3'd4);
        m_tdata_o  = 8'h00;
        if (state == RESP) begin
            case (idx)
                3'd0:    m_tdata_o = {tag_q, 1'b0, tmo_q, mis_q, err_q};
                3'd1:    m_tdata_o = data_q[7:0];
                3'd2:    m_tdata_o = data_q[15:8];
                3'd3:    m_tdata_o = data_q[23:16];
                3'd4:    m_tdata_o = data_q[31:24];
                default: m_tdata_o = 8'h00;
            endcase
        end
    end

endmodule
